// File: rtl/config_chain_readback_if.sv
// Word handshake bundle for configuration chain readback.
// Master produces packed words, slave consumes them.
interface config_chain_readback_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] WORD_OUT;
    logic              WORD_VALID;
    logic              WORD_READY;
    logic              WORD_LAST;

    modport master (
        output WORD_OUT,
        output WORD_VALID,
        output WORD_LAST,
        input  WORD_READY
    );

    modport slave (
        input  WORD_OUT,
        input  WORD_VALID,
        input  WORD_LAST,
        output WORD_READY
    );
endinterface

// File: rtl/config_chain_readback.sv
// Serial configuration chain readback: shifts the chain, samples its tail
// and packs the bits into words, optionally recirculating tail to head.
module config_chain_readback #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic CLK,
    input  logic RESET,
    input  logic START,
    input  logic RECIRC,
    input  logic CHAIN_TAIL,
    output logic SCAN_EN,
    output logic SHIFT_EN,
    output logic CHAIN_HEAD,
    output logic BUSY,
    output logic DONE,
    config_chain_readback_if.master WORD
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WC_W-1:0]   wrd_cnt;
    logic [WORD_W-1:0] sreg, sreg_nx, word_q;
    logic              valid_q, last_q, recirc_q;
    logic              last_bit, word_end, stall, accept;

    assign last_bit = bit_cnt == CNT_W'(CHAIN_LEN - 1);
    assign word_end = (wrd_cnt == WC_W'(WORD_W - 1)) || last_bit;
    assign accept   = valid_q && WORD.WORD_READY;
    assign stall    = word_end && valid_q && !WORD.WORD_READY;

    // Reset gates the shift so an aborted readback leaves the chain
    // exactly where the last sampled bit put it.
    assign SHIFT_EN   = (state == ST_SHIFT) && !stall && !RESET;
    assign SCAN_EN    = (state == ST_SHIFT) || (state == ST_DRAIN);
    assign CHAIN_HEAD = recirc_q ? CHAIN_TAIL : 1'b0;
    assign BUSY       = state != ST_IDLE;
    assign DONE       = state == ST_DONE;

    assign WORD.WORD_OUT   = word_q;
    assign WORD.WORD_VALID = valid_q;
    assign WORD.WORD_LAST  = last_q;

    always_comb begin
        sreg_nx          = sreg;
        sreg_nx[wrd_cnt] = CHAIN_TAIL;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (START) state_nx = ST_SHIFT;
            ST_SHIFT: if (SHIFT_EN && last_bit) state_nx = ST_DRAIN;
            ST_DRAIN: if (accept) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            wrd_cnt  <= '0;
            sreg     <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            recirc_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && START) begin
                bit_cnt  <= '0;
                wrd_cnt  <= '0;
                sreg     <= '0;
                recirc_q <= RECIRC;
            end
            if (accept) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            // A word load on the same edge as an accept overrides the clear.
            if (SHIFT_EN) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (word_end) begin
                    word_q  <= sreg_nx;
                    valid_q <= 1'b1;
                    last_q  <= last_bit;
                    wrd_cnt <= '0;
                    sreg    <= '0;
                end else begin
                    wrd_cnt <= wrd_cnt + WC_W'(1);
                    sreg    <= sreg_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_config_chain_readback.sv
// Bench for config_chain_readback: three chain lengths, behavioural chain
// models, scoreboard of expected words checked by a negedge monitor.
module tb_config_chain_readback;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RESET;

    logic st_a, rc_a, tail_a, scan_a, sh_a, head_a, busy_a, done_a;
    logic st_b, rc_b, tail_b, scan_b, sh_b, head_b, busy_b, done_b;
    logic st_c, rc_c, tail_c, scan_c, sh_c, head_c, busy_c, done_c;

    config_chain_readback_if #(.WORD_W(8)) wa ();
    config_chain_readback_if #(.WORD_W(8)) wb ();
    config_chain_readback_if #(.WORD_W(8)) wc ();

    config_chain_readback #(.WORD_W(8), .CHAIN_LEN(20)) dut_a (
        .CLK(CLK), .RESET(RESET), .START(st_a), .RECIRC(rc_a),
        .CHAIN_TAIL(tail_a), .SCAN_EN(scan_a), .SHIFT_EN(sh_a),
        .CHAIN_HEAD(head_a), .BUSY(busy_a), .DONE(done_a), .WORD(wa)
    );
    config_chain_readback #(.WORD_W(8), .CHAIN_LEN(16)) dut_b (
        .CLK(CLK), .RESET(RESET), .START(st_b), .RECIRC(rc_b),
        .CHAIN_TAIL(tail_b), .SCAN_EN(scan_b), .SHIFT_EN(sh_b),
        .CHAIN_HEAD(head_b), .BUSY(busy_b), .DONE(done_b), .WORD(wb)
    );
    config_chain_readback #(.WORD_W(8), .CHAIN_LEN(1)) dut_c (
        .CLK(CLK), .RESET(RESET), .START(st_c), .RECIRC(rc_c),
        .CHAIN_TAIL(tail_c), .SCAN_EN(scan_c), .SHIFT_EN(sh_c),
        .CHAIN_HEAD(head_c), .BUSY(busy_c), .DONE(done_c), .WORD(wc)
    );

    // Chain models: tail is the MSB, the head shifts in at bit 0.
    logic [19:0] ch_a, ldv_a;
    logic [15:0] ch_b, ldv_b;
    logic        ch_c, ldv_c;
    logic        ld_a, ld_b, ld_c;
    always @(posedge CLK) begin
        if (ld_a) ch_a <= ldv_a;
        else if (sh_a) ch_a <= {ch_a[18:0], head_a};
        if (ld_b) ch_b <= ldv_b;
        else if (sh_b) ch_b <= {ch_b[14:0], head_b};
        if (ld_c) ch_c <= ldv_c;
        else if (sh_c) ch_c <= head_c;
    end
    assign tail_a = ch_a[19];
    assign tail_b = ch_b[15];
    assign tail_c = ch_c;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int nsh_a = 0, nsh_b = 0, nsh_c = 0;
    int ndn_a = 0, ndn_b = 0, ndn_c = 0;
    int dcyc_a = 0, hcyc_a = 0, nw_b = 0;
    logic [8:0] q_a[$], q_b[$], q_c[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm, input logic [8:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got word %0h expected no word", nm, act);
    endtask

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (sh_a === 1'b1) nsh_a <= nsh_a + 1;
        if (sh_b === 1'b1) nsh_b <= nsh_b + 1;
        if (sh_c === 1'b1) nsh_c <= nsh_c + 1;
        if (done_a === 1'b1) begin
            ndn_a  <= ndn_a + 1;
            dcyc_a <= cyc;
        end
        if (done_b === 1'b1) ndn_b <= ndn_b + 1;
        if (done_c === 1'b1) ndn_c <= ndn_c + 1;
        if (wa.WORD_VALID === 1'b1 && wa.WORD_READY === 1'b1) begin
            if (wa.WORD_LAST) hcyc_a <= cyc;
            if (q_a.size() == 0) extra("a_word", {wa.WORD_LAST, wa.WORD_OUT});
            else chk("a_word", {23'b0, wa.WORD_LAST, wa.WORD_OUT},
                     {23'b0, q_a.pop_front()});
        end
        if (wb.WORD_VALID === 1'b1 && wb.WORD_READY === 1'b1) begin
            nw_b <= nw_b + 1;
            if (q_b.size() == 0) extra("b_word", {wb.WORD_LAST, wb.WORD_OUT});
            else chk("b_word", {23'b0, wb.WORD_LAST, wb.WORD_OUT},
                     {23'b0, q_b.pop_front()});
        end
        if (wc.WORD_VALID === 1'b1 && wc.WORD_READY === 1'b1) begin
            if (q_c.size() == 0) extra("c_word", {wc.WORD_LAST, wc.WORD_OUT});
            else chk("c_word", {23'b0, wc.WORD_LAST, wc.WORD_OUT},
                     {23'b0, q_c.pop_front()});
        end
    end

    function automatic logic [31:0] rev(input logic [31:0] s, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[n-1-k] = s[k];
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_a(input logic [19:0] v);
        ldv_a = v;
        ld_a = 1'b1;
        tick();
        ld_a = 1'b0;
    endtask

    task automatic go_a(input logic rc);
        rc_a = rc;
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
    endtask

    task automatic push_a3();
        q_a.push_back(9'h03C);
        q_a.push_back(9'h05A);
        q_a.push_back(9'h10B);
    endtask

    task automatic wait_idle(input int which, input string nm);
        logic b;
        for (int i = 0; i < 300; i++) begin
            tick();
            b = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
            if (b === 1'b0) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL %s: got busy after 300 cycles expected idle", nm);
    endtask

    // Tail sequence s0..s19 packs to 0x3C, 0x5A, 0xB (first bit = LSB).
    localparam logic [31:0] SEQ_A = 32'h000B5A3C;
    localparam logic [31:0] ROT10 = 32'h0008F2D6;
    localparam logic [31:0] SEQ_B = 32'h0000C3A5;

    initial begin
        int s0, d0, w0, cnt, sh, se;
        logic ok;
        logic [31:0] orig;
        RESET = 1'b1;
        {st_a, rc_a, st_b, rc_b, st_c, rc_c} = '0;
        {ld_a, ld_b, ld_c} = '0;
        {ldv_a, ldv_b, ldv_c} = '0;
        wa.WORD_READY = 1'b1;
        wb.WORD_READY = 1'b1;
        wc.WORD_READY = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", wa.WORD_VALID, 0);
        chk("rst_out", wa.WORD_OUT, 0);
        chk("rst_last", wa.WORD_LAST, 0);
        chk("rst_done", done_a, 0);
        chk("rst_shift", {sh_a, scan_a}, 0);
        RESET = 1'b0;
        tick();

        orig = rev(SEQ_A, 20);
        load_a(orig[19:0]);
        push_a3();
        s0 = nsh_a;
        d0 = ndn_a;
        go_a(1'b0);
        wait_idle(0, "t1_idle");
        chk("t1_shifts", nsh_a - s0, 20);
        chk("t1_done_cnt", ndn_a - d0, 1);
        chk("t1_done_lat", dcyc_a, hcyc_a + 1);
        chk("t1_q_empty", q_a.size(), 0);
        chk("t3_norecirc_zero", ch_a, 0);

        load_a(orig[19:0]);
        push_a3();
        s0 = nsh_a;
        wa.WORD_READY = 1'b0;
        go_a(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (wa.WORD_VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t2_valid_seen", ok, 1);
        sh = 0;
        se = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge CLK);
            sh += int'(sh_a);
            se = int'(sh_a);
        end
        @(posedge CLK);
        #1 wa.WORD_READY = 1'b1;
        chk("t2_bits_before_stall", sh, 7);
        chk("t2_stalled", se, 0);
        wait_idle(0, "t2_idle");
        chk("t2_shifts", nsh_a - s0, 20);
        chk("t2_q_empty", q_a.size(), 0);

        load_a(orig[19:0]);
        s0 = nsh_a;
        push_a3();
        go_a(1'b1);
        wait_idle(0, "t3_idle1");
        chk("t3_chain_kept1", ch_a, orig);
        push_a3();
        go_a(1'b1);
        wait_idle(0, "t3_idle2");
        chk("t3_chain_kept2", ch_a, orig);
        chk("t3_shifts", nsh_a - s0, 40);
        chk("t3_q_empty", q_a.size(), 0);

        load_a(orig[19:0]);
        q_a.push_back(9'h03C);
        d0 = ndn_a;
        go_a(1'b1);
        cnt = 0;
        for (int i = 0; i < 60 && cnt < 10; i++) begin
            @(negedge CLK);
            if (sh_a === 1'b1) cnt++;
        end
        chk("t4_bits", cnt, 10);
        @(posedge CLK);
        #1 RESET = 1'b1;
        tick();
        chk("t4_busy", busy_a, 0);
        chk("t4_valid", wa.WORD_VALID, 0);
        chk("t4_shift", sh_a, 0);
        RESET = 1'b0;
        repeat (5) tick();
        chk("t4_no_done", ndn_a - d0, 0);
        chk("t4_q_empty", q_a.size(), 0);
        chk("t4_chain_rot", ch_a, rev(ROT10, 20));
        q_a.push_back(9'h0D6);
        q_a.push_back(9'h0F2);
        q_a.push_back(9'h108);
        go_a(1'b1);
        wait_idle(0, "t4_idle");
        chk("t4_q_empty2", q_a.size(), 0);

        orig = rev(SEQ_B, 16);
        ldv_b = orig[15:0];
        ld_b = 1'b1;
        tick();
        ld_b = 1'b0;
        q_b.push_back(9'h0A5);
        q_b.push_back(9'h1C3);
        s0 = nsh_b;
        d0 = ndn_b;
        w0 = nw_b;
        st_b = 1'b1;
        tick();
        st_b = 1'b0;
        repeat (3) tick();
        st_b = 1'b1;
        tick();
        st_b = 1'b0;
        for (int i = 0; i < 40 && nsh_b - s0 < 12; i++) tick();
        wb.WORD_READY = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (scan_b === 1'b1 && sh_b === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_drain_seen", ok, 1);
        st_b = 1'b1;
        tick();
        st_b = 1'b0;
        repeat (2) tick();
        wb.WORD_READY = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (done_b === 1'b1) begin
                ok = 1'b1;
                st_b = 1'b1;
                @(posedge CLK);
                #1 st_b = 1'b0;
                break;
            end
        end
        chk("t5_done_seen", ok, 1);
        repeat (5) tick();
        chk("t5_idle", busy_b, 0);
        chk("t5_shifts", nsh_b - s0, 16);
        chk("t5_done_cnt", ndn_b - d0, 1);
        chk("t5_words", nw_b - w0, 2);
        chk("t5_q_empty", q_b.size(), 0);

        ldv_c = 1'b1;
        ld_c = 1'b1;
        tick();
        ld_c = 1'b0;
        q_c.push_back(9'h101);
        s0 = nsh_c;
        d0 = ndn_c;
        st_c = 1'b1;
        tick();
        st_c = 1'b0;
        wait_idle(2, "t6_idle");
        chk("t6_shifts", nsh_c - s0, 1);
        chk("t6_done_cnt", ndn_c - d0, 1);
        chk("t6_chain", ch_c, 0);
        chk("t6_q_empty", q_c.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/config_chain_readback.md
Name: config_chain_readback

Overview:
- Reads back the serial configuration chain built from scan-enabled muxes and DFFs in the fabric.
- Drives the chain's shift enable, samples the bits arriving at the chain tail, and packs them into WORD_W-bit words on a valid/ready interface.
- Optional recirculation feeds the tail back to the head, so a full readback restores the chain contents.

Parameters:
WORD_W, 8, bits per output word; first bit sampled lands in WORD_OUT[0].
CHAIN_LEN, 64, number of flops in the chain (at least 1); derived localparam CNT_W = $clog2(CHAIN_LEN+1).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  reset; synchronous, active-high.
START  input  1  one-cycle request to begin a readback; ignored while BUSY=1.
RECIRC  input  1  1 = chain head is fed from chain tail (non-destructive readback); sampled at START.
CHAIN_TAIL  input  1  serial output of the last chain flop.
SCAN_EN  output  1  puts the chain in shift mode; 1 in SHIFT and DRAIN.
SHIFT_EN  output  1  chain clock enable; the chain advances one position on each edge where this is 1.
CHAIN_HEAD  output  1  serial input to the first chain flop: CHAIN_TAIL if the latched RECIRC is 1, else 0.
WORD_OUT  output  WORD_W  packed readback word.
WORD_VALID  output  1  WORD_OUT holds an unconsumed word.
WORD_READY  input  1  consumer accepts the word on an edge where WORD_VALID=1 and WORD_READY=1.
WORD_LAST  output  1  qualifies WORD_OUT as the final word of this readback.
BUSY  output  1  1 when state is not IDLE.
DONE  output  1  one-cycle pulse when a readback completes.

Behaviour:
- Reset values: state IDLE, all counters 0, shift register 0, WORD_OUT 0, WORD_VALID 0, WORD_LAST 0, DONE 0, latched RECIRC 0. Reset mid-readback aborts on the same edge; the chain is left in whatever position it has reached.
- States:
  - IDLE: on START go to SHIFT. Clear the bit counter (0..CHAIN_LEN-1), the in-word counter (0..WORD_W-1) and the shift register; latch RECIRC.
  - SHIFT: SCAN_EN=1. SHIFT_EN is combinational: 1 unless a stall applies.
  - Stall condition: (in-word counter = WORD_W-1, or bit counter = CHAIN_LEN-1) and WORD_VALID=1 and WORD_READY=0. The combinational path from WORD_READY to SHIFT_EN is intentional.
  - Sampling: on each edge with SHIFT_EN=1, CHAIN_TAIL is captured into bit position (in-word counter) and both counters increment. The captured value is the tail as it stands before the chain advances on that same edge.
  - Word completion: on the sample where the in-word counter is WORD_W-1, or the bit counter is CHAIN_LEN-1, load the completed word into WORD_OUT, set WORD_VALID=1, and clear the in-word counter and shift register.
  - Partial final word: unsampled upper bits are 0.
  - WORD_LAST is set with the word containing bit CHAIN_LEN-1. After that sample, go to DRAIN.
  - DRAIN: SHIFT_EN=0. When the final word is accepted, go to DONE.
  - DONE: DONE=1 for exactly one cycle, then go to IDLE. BUSY is still 1 in this cycle.
- Handshake: WORD_VALID, WORD_OUT and WORD_LAST are held stable until accepted. If acceptance and a new word load happen on the same edge, the new word wins and WORD_VALID stays 1.
- Latency: the first word becomes valid on the edge of the WORD_W-th SHIFT_EN cycle; the first SHIFT_EN cycle is the one after the START edge.
- Total SHIFT_EN=1 cycles per readback are exactly CHAIN_LEN, independent of backpressure.
- Word count per readback is ceil(CHAIN_LEN/WORD_W).
- START while BUSY=1 has no effect. START asserted in the DONE cycle is also ignored.

Test Plan:
1. WORD_W=8, CHAIN_LEN=20; chain model emits tail bits forming 0x3C, 0x5A, then 4 bits 1011; READY=1, START once -> words 0x3C, 0x5A, 0x0B, WORD_LAST=1 only on 0x0B; exactly 20 SHIFT_EN cycles; DONE pulses once, 1 cycle after the 0x0B handshake.
2. Same setup, hold READY=0 for 12 cycles after 0x3C is valid -> SHIFT_EN drops after 7 further bits and stays 0 until READY=1; word sequence unchanged; SHIFT_EN total still 20.
3. RECIRC=1: two back-to-back readbacks -> both produce 0x3C, 0x5A, 0x0B; chain model contents equal the original after each. With RECIRC=0, the chain model is all zeros after the first readback.
4. RECIRC=1, RESET asserted after 10 sampled bits -> next cycle BUSY=0, WORD_VALID=0, SHIFT_EN=0, DONE never pulses. A new START reads the chain rotated by 10 (first word = bits b10..b17).
5. CHAIN_LEN=16 -> exactly two words with no padding, WORD_LAST on the second. START pulses during SHIFT, DRAIN and DONE are all ignored (one DONE pulse, two words total).
6. CHAIN_LEN=1 -> a single word equal to {7'b0, tail bit}, WORD_LAST=1, one SHIFT_EN cycle.
